regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath, with a configurable number of read and write ports.
- Adds an optional write-to-read bypass, an optional hardwired-zero register 0 and a per-register pending-write scoreboard.
- Sits between decode (read ports, scoreboard set) and writeback (write ports).

Parameters:
- ADDR_W, 5: address width; depth = 2**ADDR_W registers.
- BUS_W, 32: data width of each register.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.
- ZERO_REG, 1: if 1, register 0 reads 0, ignores writes and is never marked busy.
- BYPASS, 1: if 1, a same-cycle write is forwarded to reads of the same address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_en  in  NUM_WR  write enable, one bit per write port.
- w_addr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- w_data  in  NUM_WR*BUS_W  write data; port k occupies bits [k*BUS_W +: BUS_W].
- r_addr  in  NUM_RD*ADDR_W  read addresses, packed the same way.
- r_data  out  NUM_RD*BUS_W  read data, combinational.
- r_busy  out  NUM_RD  1 when the addressed register has a pending write.
- sb_set  in  1  mark register sb_addr busy (instruction issued).
- sb_addr  in  ADDR_W  scoreboard set address.

Behaviour:
- Reset (rst=0, asynchronous): all registers clear to 0 and all busy bits clear to 0. While in reset, r_data is 0 and r_busy is 0 for every port. Reset asserted mid-write aborts the write; no partial update survives.
- Writes: on the rising edge, each port k with w_en[k]=1 writes w_data[k] to w_addr[k].
- Same-address writes: the highest-indexed enabled port wins.
- Zero register: with ZERO_REG=1, writes to address 0 are discarded.
- Read path: reads are combinational with zero latency. r_data[j] = mem[r_addr[j]].
  - With ZERO_REG=1, address 0 always reads 0.
  - With BYPASS=1, if any enabled write port targets r_addr[j] this cycle, r_data[j] is that port's data. Same priority rule applies (highest index wins). Address 0 is never bypassed when ZERO_REG=1.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard: one busy bit per register.
  - Set on the edge when sb_set=1 at sb_addr.
  - Cleared on the edge when any enabled write port targets that address.
  - Set and clear of the same address in the same cycle: set wins, because a new producer was issued.
  - With ZERO_REG=1, busy[0] is forced to 0.
- r_busy[j] = busy[r_addr[j]], with this exception: when BYPASS=1 and a write to r_addr[j] occurs in the same cycle, r_busy[j]=0, because the data is being forwarded. This applies even if sb_set targets the same address that cycle; the registered set takes effect next cycle.
- Independence: all ports operate every cycle. There are no stalls and no handshakes.
- Arithmetic: none; no width conversion. Addresses wrap naturally within ADDR_W.

Test Plan:
- Reset: hold rst=0, drive w_en=2'b11 -> all r_data=0 and r_busy=0. Release rst, read address 5 -> 0.
- Basic write/read: write 0xDEADBEEF to reg 7 on port 0. Next cycle, read port 0 and read port 1 both at address 7 -> 0xDEADBEEF on both.
- Write collision: same cycle, port 0 writes 0x11111111 and port 1 writes 0x22222222 to reg 3.
  - Same-cycle read of 3 (BYPASS=1) -> 0x22222222.
  - Next cycle -> 0x22222222.
  - With BYPASS=0, the same-cycle read returns the old value 0.
- Zero register: write 0xFFFFFFFF to reg 0 with sb_set at addr 0 -> reads of 0 return 0 and r_busy=0 on every cycle.
- Scoreboard:
  - sb_set on reg 9 -> r_busy=1 from the next cycle.
  - Write to reg 9 -> r_busy=0 in the write cycle (BYPASS=1) and thereafter.
  - sb_set and write to reg 9 in the same cycle -> r_busy=1 the next cycle.
- Reset mid-operation: after regs 1..4 are written and reg 2 is marked busy, pulse rst=0 asynchronously between edges -> all data and busy bits read 0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, hardwired zero
// register and a per-register pending-write scoreboard.
module regfile_mp #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned BUS_W    = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_WR-1:0]          w_en,
   input  logic [NUM_WR*ADDR_W-1:0]   w_addr,
   input  logic [NUM_WR*BUS_W-1:0]    w_data,
   input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
   output logic [NUM_RD*BUS_W-1:0]    r_data,
   output logic [NUM_RD-1:0]          r_busy,
   input  logic                       sb_set,
   input  logic [ADDR_W-1:0]          sb_addr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [BUS_W-1:0] mem_q [DEPTH];
   logic [BUS_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Next register contents: ports applied in ascending order so the highest index wins.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         if (w_en[k] && !(ZERO_REG && (w_addr[k*ADDR_W +: ADDR_W] == '0))) begin
            mem_d[w_addr[k*ADDR_W +: ADDR_W]] = w_data[k*BUS_W +: BUS_W];
         end
      end
   end

   // Next scoreboard: writes clear, a new issue sets afterwards so set wins.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         if (w_en[k]) begin
            busy_d[w_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (sb_set) begin
         busy_d[sb_addr] = 1'b1;
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   // State registers; reset discards any in-flight write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      r_data = '0;
      r_busy = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         logic [ADDR_W-1:0] ra;
         logic [BUS_W-1:0]  rd;
         logic              rb;
         ra = r_addr[j*ADDR_W +: ADDR_W];
         rd = mem_q[ra];
         rb = busy_q[ra];
         if (BYPASS) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
               if (w_en[k] && (w_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                  rd = w_data[k*BUS_W +: BUS_W];
                  rb = 1'b0;
               end
            end
         end
         if (ZERO_REG && (ra == '0)) begin
            rd = '0;
            rb = 1'b0;
         end
         if (!rst) begin
            rd = '0;
            rb = 1'b0;
         end
         r_data[j*BUS_W +: BUS_W] = rd;
         r_busy[j]                = rb;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    en  = '0;
   logic [AW-1:0] wa [2];
   logic [DW-1:0] wd [2];
   logic [AW-1:0] ra [2];
   logic          sb_set = 1'b0;
   logic [AW-1:0] sb_addr = '0;

   logic [2*AW-1:0] w_addr, r_addr;
   logic [2*DW-1:0] w_data;
   logic [2*DW-1:0] r_data_b, r_data_n;
   logic [1:0]      r_busy_b, r_busy_n;

   assign w_addr = {wa[1], wa[0]};
   assign w_data = {wd[1], wd[0]};
   assign r_addr = {ra[1], ra[0]};

   // Reference state
   logic [DW-1:0] ref_mem [32];
   bit            ref_busy [32];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .w_en(en), .w_addr(w_addr), .w_data(w_data),
      .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
      .sb_set(sb_set), .sb_addr(sb_addr)
   );

   regfile_mp #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .w_en(en), .w_addr(w_addr), .w_data(w_data),
      .r_addr(r_addr), .r_data(r_data_n), .r_busy(r_busy_n),
      .sb_set(sb_set), .sb_addr(sb_addr)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(int j, bit byp);
      logic [DW-1:0] v;
      if (!rst || ra[j] == 0) return '0;
      v = ref_mem[ra[j]];
      if (byp) begin
         for (int k = 0; k < 2; k++) if (en[k] && wa[k] == ra[j]) v = wd[k];
      end
      return v;
   endfunction

   function automatic logic exp_busy(int j, bit byp);
      if (!rst || ra[j] == 0) return 1'b0;
      if (byp) begin
         for (int k = 0; k < 2; k++) if (en[k] && wa[k] == ra[j]) return 1'b0;
      end
      return ref_busy[ra[j]];
   endfunction

   task automatic check_all();
      for (int j = 0; j < 2; j++) begin
         check($sformatf("byp_data%0d", j), r_data_b[j*DW +: DW], exp_data(j, 1'b1));
         check($sformatf("byp_busy%0d", j), DW'(r_busy_b[j]), DW'(exp_busy(j, 1'b1)));
         check($sformatf("nb_data%0d", j), r_data_n[j*DW +: DW], exp_data(j, 1'b0));
         check($sformatf("nb_busy%0d", j), DW'(r_busy_n[j]), DW'(exp_busy(j, 1'b0)));
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         ref_mem[i]  = '0;
         ref_busy[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_clear();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         if (en[k] && wa[k] != 0) ref_mem[wa[k]] = wd[k];
         if (en[k]) ref_busy[wa[k]] = 1'b0;
      end
      if (sb_set) ref_busy[sb_addr] = 1'b1;
      ref_busy[0] = 1'b0;
   endtask

   // Check mid-cycle, then advance the model across the rising edge.
   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic [1:0] e, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                        input logic s, input logic [AW-1:0] sa);
      en = e; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
      ra[0] = r0; ra[1] = r1; sb_set = s; sb_addr = sa;
   endtask

   initial begin
      model_clear();
      // Reset held with both write ports active
      drive(2'b11, 5'd5, 32'hAAAA5555, 5'd6, 32'h12345678, 5'd5, 5'd6, 1'b1, 5'd5);
      step();
      step();
      check("rst_data0", r_data_b[DW-1:0], 32'h0);
      rst = 1'b1;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
      step();

      // Basic write then read on both ports
      drive(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
      #1;
      check("basic_p0", r_data_b[DW-1:0], 32'hDEADBEEF);
      check("basic_p1", r_data_b[2*DW-1:DW], 32'hDEADBEEF);
      step();

      // Write collision on reg 3
      drive(2'b11, 5'd3, 32'h11111111, 5'd3, 32'h22222222, 5'd3, 5'd3, 1'b0, 5'd0);
      #1;
      check("coll_byp", r_data_b[DW-1:0], 32'h22222222);
      check("coll_nb", r_data_n[DW-1:0], 32'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
      #1;
      check("coll_next", r_data_n[DW-1:0], 32'h22222222);
      step();

      // Zero register with scoreboard set at 0
      drive(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
      step();

      // Scoreboard set, write-clear, and set+write same cycle
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
      #1;
      check("sb_busy", DW'(r_busy_b[0]), 32'h1);
      step();
      drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 5'd9, 5'd9, 1'b0, 5'd0);
      #1;
      check("sb_wclr", DW'(r_busy_b[0]), 32'h0);
      step();
      drive(2'b01, 5'd9, 32'h9A, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
      #1;
      check("sb_setwins", DW'(r_busy_b[1]), 32'h1);
      step();

      // Registers 1..4 written, reg 2 busy, then async reset pulse between edges
      for (int i = 1; i <= 4; i++) begin
         drive(2'b01, AW'(i), DW'(32'hC0DE0000 + i), 5'd0, 32'h0, AW'(i), 5'd2,
               (i == 4) ? 1'b1 : 1'b0, 5'd2);
         step();
      end
      drive(2'b01, 5'd3, 32'h5555AAAA, 5'd0, 32'h0, 5'd2, 5'd4, 1'b0, 5'd0);
      #1;
      rst = 1'b0;
      #1;
      check_all();
      model_clear();
      #1;
      rst = 1'b1;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd4, 1'b0, 5'd0);
      #1;
      check_all();
      step();

      // Random traffic on a narrow address range to force collisions
      for (int c = 0; c < 400; c++) begin
         drive(2'($urandom), AW'($urandom_range(0, 7)), $urandom,
               AW'($urandom_range(0, 7)), $urandom,
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               1'($urandom), AW'($urandom_range(0, 7)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
